onchip_mem_bist_ctrl: RTL and testbench

- Built-in self-test sequencer for the 128K x 32 on-chip RAM used by the board test system. It drives one Avalon-style memory port (address, byteenable, chipselect, write, writedata, clken) and receives readdata.
- It writes a selected data pattern over a programmable address window, then reads the window back and compares every word against the same pattern.
- Results (pass, error count, first failing address) go to the BTS host-visible CSR block.

---
 rtl/onchip_mem_bist_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_onchip_mem_bist_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_bist_ctrl.sv
// Built-in self-test sequencer for the on-chip RAM: writes a selected data
// pattern over an address window, reads it back and compares every word,
// reporting pass, a saturating error count and the first failing address.
module onchip_mem_bist_ctrl #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32,
    parameter int ERR_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            pattern_sel,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       num_words,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_W-1:0]      err_count,
    output logic [ADDR_W-1:0]     first_fail_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   num_q;
    logic [1:0]        psel_q;
    logic              cmp_valid;
    logic [DATA_W-1:0] cmp_exp;
    logic [ADDR_W-1:0] cmp_addr;
    logic [ERR_W-1:0]  err_nx;
    logic [ADDR_W-1:0] ffa_nx;
    logic              accept;
    logic              last_word;

    // Test data for a given (already wrapped) word address.
    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] sel,
                                                  input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] p;
        logic [31:0]       c;
        p = '0;
        c = (sel == 2'd2) ? 32'h5555AAAA : 32'hAAAA5555;
        case (sel)
            2'd0: p[ADDR_W-1:0] = a;
            2'd1: begin
                p[ADDR_W-1:0] = a;
                p = ~p;
            end
            default: begin
                for (int unsigned i = 0; i < DATA_W; i++) p[i] = c[i % 32];
            end
        endcase
        return p;
    endfunction

    assign accept    = ((state == S_IDLE) || (state == S_DONE)) && start && !abort;
    assign last_word = (remaining == {{ADDR_W{1'b0}}, 1'b1});

    // Next-state selection; abort overrides everything.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) state_nx = (num_words == '0) ? S_DONE : S_WRITE;
            end
            S_WRITE: if (last_word) state_nx = S_READ;
            S_READ:  if (last_word) state_nx = S_DRAIN;
            S_DRAIN: state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
        if (abort) state_nx = S_IDLE;
    end

    // Memory port and status strobes decoded from the current state.
    always_comb begin
        mem_chipselect = (state == S_WRITE) || (state == S_READ);
        mem_write      = (state == S_WRITE);
        mem_address    = mem_chipselect ? addr : '0;
        mem_writedata  = mem_write ? pattern(psel_q, addr) : '0;
        mem_byteenable = {(DATA_W/8){mem_chipselect}};
        mem_clken      = 1'b1;
        busy           = (state == S_WRITE) || (state == S_READ) || (state == S_DRAIN);
    end

    // Compare stage: read data arrives the cycle after its address was issued.
    always_comb begin
        err_nx = err_count;
        ffa_nx = first_fail_addr;
        if (cmp_valid && (mem_readdata != cmp_exp)) begin
            if (err_count != '1) err_nx = err_count + ERR_W'(1);
            if (err_count == '0) ffa_nx = cmp_addr;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Address walk, configuration latch, compare pipeline and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr            <= '0;
            remaining       <= '0;
            base_q          <= '0;
            num_q           <= '0;
            psel_q          <= '0;
            cmp_valid       <= 1'b0;
            cmp_exp         <= '0;
            cmp_addr        <= '0;
            err_count       <= '0;
            first_fail_addr <= '0;
            done            <= 1'b0;
            pass            <= 1'b0;
        end else if (abort) begin
            done      <= 1'b0;
            pass      <= 1'b0;
            cmp_valid <= 1'b0;
        end else begin
            cmp_valid       <= 1'b0;
            err_count       <= err_nx;
            first_fail_addr <= ffa_nx;
            case (state)
                S_WRITE: begin
                    if (last_word) begin
                        addr      <= base_q;
                        remaining <= num_q;
                    end else begin
                        addr      <= addr + 1'b1;
                        remaining <= remaining - 1'b1;
                    end
                end
                S_READ: begin
                    cmp_valid <= 1'b1;
                    cmp_exp   <= pattern(psel_q, addr);
                    cmp_addr  <= addr;
                    addr      <= addr + 1'b1;
                    remaining <= remaining - 1'b1;
                end
                S_DRAIN: begin
                    done <= 1'b1;
                    pass <= (err_nx == '0);
                end
                default: ;
            endcase
            if (accept) begin
                base_q <= base_addr;
                num_q  <= num_words;
                psel_q <= pattern_sel;
                if (num_words == '0) begin
                    done <= 1'b1;
                    pass <= 1'b1;
                end else begin
                    done            <= 1'b0;
                    pass            <= 1'b0;
                    err_count       <= '0;
                    first_fail_addr <= '0;
                    addr            <= base_addr;
                    remaining       <= num_words;
                end
            end
        end
    end

endmodule

// File: tb/tb_onchip_mem_bist_ctrl.sv
// Directed self-checking bench for onchip_mem_bist_ctrl with a behavioural
// RAM model (registered address, unregistered read data, fault modes).
module tb_onchip_mem_bist_ctrl;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 32;
    localparam int ERR_W  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic [1:0]        pattern_sel;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   num_words;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ERR_W-1:0]  err_count;
    logic [ADDR_W-1:0] first_fail_addr;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Memory model: 0 ideal, 1 bit 3 flipped on reads of word 5, 2 reads return 0.
    int                mode = 0;
    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] raddr = '0;

    // Bus monitor logs.
    int                wcount = 0;
    int                rcount = 0;
    int                be_bad = 0;
    logic [ADDR_W-1:0] waddr_log [0:1023];
    logic [31:0]       wdata_log [0:1023];

    onchip_mem_bist_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ERR_W(ERR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .pattern_sel(pattern_sel), .base_addr(base_addr), .num_words(num_words),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_fail_addr(first_fail_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                mem[mem_address] <= mem_writedata;
                if (wcount < 1024) begin
                    waddr_log[wcount] <= mem_address;
                    wdata_log[wcount] <= mem_writedata;
                end
                wcount <= wcount + 1;
            end else begin
                raddr  <= mem_address;
                rcount <= rcount + 1;
            end
            if (mem_byteenable !== 4'hF) be_bad <= be_bad + 1;
        end else if (mem_byteenable !== 4'h0) be_bad <= be_bad + 1;
    end

    assign mem_readdata = (mode == 2) ? 32'h0 :
                          ((mode == 1) && (raddr == 17'd5)) ? (mem[raddr] ^ 32'h8) :
                          mem[raddr];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_done(input int maxc);
        while (!done && cyc < maxc) step();
        check("done_timeout", 64'(done), 64'd1);
    endtask

    task automatic setup(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n,
                         input logic [1:0] p);
        base_addr   = b;
        num_words   = n;
        pattern_sel = p;
    endtask

    int w0, r0;

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        setup('0, '0, 2'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_clken", 64'(mem_clken), 64'd1);
        check("rst_cs", 64'(mem_chipselect), 64'd0);
        check("rst_we", 64'(mem_write), 64'd0);
        check("rst_be", 64'(mem_byteenable), 64'd0);
        check("rst_addr", 64'(mem_address), 64'd0);
        check("rst_wdata", 64'(mem_writedata), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pass", 64'(pass), 64'd0);
        check("rst_err", 64'(err_count), 64'd0);
        check("rst_ffa", 64'(first_fail_addr), 64'd0);
        reset = 1'b0;
        step();

        // 16 words, pattern 0 from address 0
        setup(17'h0, 18'd16, 2'd0);
        w0 = wcount; r0 = rcount;
        start_pulse();
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_first_addr", 64'(mem_address), 64'h0);
        wait_done(100);
        check("t1_latency", 64'(cyc), 64'd34);
        check("t1_pass", 64'(pass), 64'd1);
        check("t1_err", 64'(err_count), 64'd0);
        check("t1_writes", 64'(wcount - w0), 64'd16);
        check("t1_reads", 64'(rcount - r0), 64'd16);
        check("t1_wdata15", 64'(wdata_log[w0 + 15]), 64'd15);
        check("t1_busy_done", 64'(busy), 64'd0);

        // Window wrapping past the top of memory, pattern 1
        setup(17'h1FFFE, 18'd4, 2'd1);
        w0 = wcount;
        start_pulse();
        wait_done(40);
        check("t2_latency", 64'(cyc), 64'd10);
        check("t2_a0", 64'(waddr_log[w0]), 64'h1FFFE);
        check("t2_d0", 64'(wdata_log[w0]), 64'hFFFE0001);
        check("t2_a2", 64'(waddr_log[w0 + 2]), 64'h0);
        check("t2_d2", 64'(wdata_log[w0 + 2]), 64'hFFFFFFFF);
        check("t2_a3", 64'(waddr_log[w0 + 3]), 64'h1);
        check("t2_d3", 64'(wdata_log[w0 + 3]), 64'hFFFFFFFE);
        check("t2_pass", 64'(pass), 64'd1);

        // Single corrupted word at address 5, pattern 2
        mode = 1;
        setup(17'h0, 18'd16, 2'd2);
        w0 = wcount;
        start_pulse();
        wait_done(100);
        check("t3_wdata", 64'(wdata_log[w0 + 3]), 64'h5555AAAA);
        check("t3_err", 64'(err_count), 64'd1);
        check("t3_ffa", 64'(first_fail_addr), 64'd5);
        check("t3_pass", 64'(pass), 64'd0);

        // Empty test completes in one cycle with no memory traffic
        setup(17'h33, 18'd0, 2'd0);
        w0 = wcount; r0 = rcount;
        start_pulse();
        check("t4_done", 64'(done), 64'd1);
        check("t4_pass", 64'(pass), 64'd1);
        check("t4_busy", 64'(busy), 64'd0);
        step();
        check("t4_no_wr", 64'(wcount - w0), 64'd0);
        check("t4_no_rd", 64'(rcount - r0), 64'd0);

        // Every read mismatches: error count saturates, pattern 3
        mode = 2;
        setup(17'h40, 18'd300, 2'd3);
        w0 = wcount;
        start_pulse();
        wait_done(700);
        check("t5_latency", 64'(cyc), 64'd602);
        check("t5_wdata", 64'(wdata_log[w0]), 64'hAAAA5555);
        check("t5_err_sat", 64'(err_count), 64'hFF);
        check("t5_ffa", 64'(first_fail_addr), 64'h40);
        check("t5_pass", 64'(pass), 64'd0);

        // Abort during WRITE at word 7
        mode = 0;
        setup(17'h0, 18'd16, 2'd0);
        start_pulse();
        repeat (7) step();
        check("t6_addr7", 64'(mem_address), 64'd7);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t6_cs", 64'(mem_chipselect), 64'd0);
        check("t6_we", 64'(mem_write), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_done", 64'(done), 64'd0);
        check("t6_pass", 64'(pass), 64'd0);
        check("t6_err", 64'(err_count), 64'd0);

        // Abort during READ after a mismatch: results hold
        mode = 1;
        start_pulse();
        while (cyc < 27) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t7_busy", 64'(busy), 64'd0);
        check("t7_done", 64'(done), 64'd0);
        check("t7_err_hold", 64'(err_count), 64'd1);
        check("t7_ffa_hold", 64'(first_fail_addr), 64'd5);
        repeat (3) step();
        check("t7_idle", 64'(mem_chipselect), 64'd0);
        check("t7_err_hold2", 64'(err_count), 64'd1);

        // Fresh run after abort completes cleanly
        mode = 0;
        start_pulse();
        wait_done(100);
        check("t8_latency", 64'(cyc), 64'd34);
        check("t8_pass", 64'(pass), 64'd1);
        check("t8_ffa", 64'(first_fail_addr), 64'd0);

        // Start pulse while busy with changed configuration is ignored
        setup(17'h10, 18'd8, 2'd0);
        w0 = wcount;
        start_pulse();
        repeat (3) step();
        setup(17'h100, 18'd3, 2'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(60);
        check("t9_latency", 64'(cyc), 64'd18);
        check("t9_writes", 64'(wcount - w0), 64'd8);
        check("t9_a0", 64'(waddr_log[w0]), 64'h10);
        check("t9_a7", 64'(waddr_log[w0 + 7]), 64'h17);
        check("t9_d7", 64'(wdata_log[w0 + 7]), 64'h17);
        check("t9_pass", 64'(pass), 64'd1);

        // Start and abort together from DONE: abort wins
        setup(17'h0, 18'd4, 2'd0);
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        check("t10_busy", 64'(busy), 64'd0);
        check("t10_done", 64'(done), 64'd0);
        step();
        check("t10_cs", 64'(mem_chipselect), 64'd0);

        // Asynchronous reset mid-run
        mode = 1;
        setup(17'h0, 18'd16, 2'd0);
        start_pulse();
        while (cyc < 26) step();
        check("t11_err_pre", 64'(err_count), 64'd1);
        reset = 1'b1;
        #1;
        check("t11_busy", 64'(busy), 64'd0);
        check("t11_cs", 64'(mem_chipselect), 64'd0);
        check("t11_err", 64'(err_count), 64'd0);
        check("t11_ffa", 64'(first_fail_addr), 64'd0);
        check("t11_clken", 64'(mem_clken), 64'd1);
        step();
        reset = 1'b0;

        check("byteenable", 64'(be_bad), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
